fetch_npc_predecode: RTL

//  Stage-1 fetch sequencer. Holds the fetch PC and issues one request at a time to instruction memory.

---
 rtl/fetch_npc_predecode.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fetch_npc_predecode.sv
// ---------------------------------------------------------------------------
// fetch_npc_predecode: single-outstanding fetch sequencer with next-PC predecode
// and RAS control. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_npc_predecode #(
  parameter logic [47:0] RESET_PC = 48'h0000_0000_1000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        redirect_valid,
  input  logic [47:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [47:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [47:0] dec_pc,
  output logic [31:0] dec_instr,
  output logic        dec_pred_taken,
  output logic [47:0] dec_pred_npc,
  output logic        ras_push,
  output logic        ras_pop,
  output logic        ras_replace,
  output logic [47:0] ras_idata,
  input  logic [47:0] ras_odata
);

  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [47:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1;
  logic        rd_link, rs1_link;
  logic [47:0] j_imm, b_imm, pc_plus4;
  logic        pred_taken;
  logic [47:0] pred_npc;
  logic        push_c, pop_c, repl_c;
  logic        accept;
  logic        unused_low_bits;

  assign opcode   = instr_q[6:0];
  assign rd       = instr_q[11:7];
  assign rs1      = instr_q[19:15];
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign j_imm    = {{28{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign b_imm    = {{36{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign pc_plus4 = pc_q + 48'd4;

  assign unused_low_bits = ^{redirect_pc[1:0], ras_odata[1:0]};

  always_comb begin
    pred_taken = 1'b0;
    pred_npc   = pc_plus4;
    push_c     = 1'b0;
    pop_c      = 1'b0;
    repl_c     = 1'b0;
    case (opcode)
      OP_JAL: begin
        pred_taken = 1'b1;
        pred_npc   = pc_q + j_imm;
        push_c     = rd_link;
      end
      OP_BRANCH: begin
        // Backward-taken / forward-not-taken: the sign of the offset decides.
        if (b_imm[47]) begin
          pred_taken = 1'b1;
          pred_npc   = pc_q + b_imm;
        end
      end
      OP_JALR: begin
        // rd==rs1 link is a call through the link register, not a return.
        if (rs1_link && !(rd_link && (rd == rs1))) begin
          pred_taken = 1'b1;
          pred_npc   = {ras_odata[47:2], 2'b00};
        end
        if (rd_link) begin
          if (!rs1_link || (rd == rs1)) push_c = 1'b1;
          else                          repl_c = 1'b1;
        end else if (rs1_link) begin
          pop_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign imem_req_valid = (state_q == S_REQ) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign dec_valid      = (state_q == S_HOLD) && !redirect_valid;
  assign dec_pc         = pc_q;
  assign dec_instr      = instr_q;
  assign dec_pred_taken = pred_taken;
  assign dec_pred_npc   = pred_npc;
  assign accept         = dec_valid && dec_ready;
  assign ras_push       = accept && push_c;
  assign ras_pop        = accept && pop_c;
  assign ras_replace    = accept && repl_c;
  assign ras_idata      = pc_plus4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[47:2], 2'b00};
      case (state_q)
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        // A response landing in DROP still retires the outstanding request.
        S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: if (imem_req_valid && imem_req_ready) state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rsp_valid) begin
            instr_d = imem_rsp_data;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (accept) begin
            pc_d    = pred_npc;
            state_d = S_REQ;
          end
        end
        S_DROP: if (imem_rsp_valid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

endmodule

`default_nettype wire
